// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style bus initiator.
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_WORD  = 2'b11;

  // A request with no byte lanes selected is treated as a full-word access.
  function automatic logic [1:0] promote_be(input logic [1:0] be);
    return (be == 2'b00) ? BE_WORD : be;
  endfunction

endpackage

// File: rtl/m68k_bus_master_dtack_sync.sv
// Two-flop synchronizer for the active-low DTACK input; both stages reset
// to the negated level so a fresh reset never looks like an acknowledge.
module dtack_sync (
  input  logic Clk,
  input  logic Reset_H,
  input  logic async_l,
  output logic sync_l
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state: shift the raw input through two stages.
  always_comb begin
    meta_d = async_l;
    sync_d = meta_q;
  end

  // Register both stages with synchronous reset to 1.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_l = sync_q;

endmodule

// File: rtl/m68k_bus_master.sv
// Single-channel 68000-style asynchronous bus initiator.
// Runs one AS/UDS/LDS cycle per accepted client request, waits for DTACK,
// reports completion with a one-cycle Done pulse and flags a bus error on
// timeout. Define M68K_BUS_MASTER_DTACK_SYNC_EN to pass DtackIn_L through a
// 2-flop synchronizer when the responder is not synchronous to Clk.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 16,
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clk,
  input  logic              Reset_H,
  input  logic              ReqValid_H,
  output logic              ReqReady_H,
  input  logic              ReqWrite_H,
  input  logic [ADDR_W-1:0] ReqAddress,
  input  logic [1:0]        ReqByteEn,
  input  logic [DATA_W-1:0] ReqWriteData,
  output logic              Done_H,
  output logic              BusError_H,
  output logic [DATA_W-1:0] ReadData,
  output logic [ADDR_W-1:0] AddressOut,
  output logic              RW_L,
  output logic              AS_L,
  output logic              UDS_L,
  output logic              LDS_L,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataOutEnable_H,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              DtackIn_L
);

  localparam int SC_W = $clog2(SETUP_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic dtack_l;

`ifdef M68K_BUS_MASTER_DTACK_SYNC_EN
  dtack_sync u_dtack_sync (
    .Clk     (Clk),
    .Reset_H (Reset_H),
    .async_l (DtackIn_L),
    .sync_l  (dtack_l)
  );
`else
  assign dtack_l = DtackIn_L;
`endif

  state_e            state_q, state_d;
  logic [SC_W-1:0]   setup_cnt_q, setup_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d, to_cnt_inc;
  logic [1:0]        be_q, be_d;
  logic              req_ready_q, req_ready_d;
  logic              done_q, done_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_l_q, rw_l_d;
  logic              as_l_q, as_l_d;
  logic              uds_l_q, uds_l_d;
  logic              lds_l_q, lds_l_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;

  assign to_cnt_inc = to_cnt_q + TO_W'(1);

  // Next-state and next-output logic for the bus cycle FSM.
  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    to_cnt_d    = to_cnt_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    done_d      = 1'b0;
    bus_err_d   = 1'b0;
    read_data_d = read_data_q;
    addr_d      = addr_q;
    rw_l_d      = rw_l_q;
    as_l_d      = as_l_q;
    uds_l_d     = uds_l_q;
    lds_l_d     = lds_l_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;

    case (state_q)
      IDLE: begin
        if (ReqValid_H && req_ready_q) begin
          addr_d      = ReqAddress;
          rw_l_d      = ReqWrite_H ? RW_WRITE : RW_READ;
          be_d        = promote_be(ReqByteEn);
          data_out_d  = ReqWrite_H ? ReqWriteData : data_out_q;
          data_oe_d   = ReqWrite_H;
          setup_cnt_d = '0;
          req_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end

      // The accept edge already drives address/RW/data; AS_L follows after
      // SETUP_CYCLES further cycles of stable address.
      SETUP: begin
        if (setup_cnt_q == SC_W'(SETUP_CYCLES)) begin
          as_l_d   = 1'b0;
          uds_l_d  = ~be_q[1];
          lds_l_d  = ~be_q[0];
          to_cnt_d = '0;
          state_d  = STROBE;
        end else begin
          setup_cnt_d = setup_cnt_q + SC_W'(1);
        end
      end

      // DTACK is checked before the timeout so a same-cycle tie completes
      // cleanly.
      STROBE: begin
        to_cnt_d = to_cnt_inc;
        if (!dtack_l || (to_cnt_inc == TO_W'(TIMEOUT_CYCLES))) begin
          if (!dtack_l && (rw_l_q == RW_READ)) begin
            read_data_d = DataIn;
          end
          bus_err_d = dtack_l;
          done_d    = 1'b1;
          as_l_d    = 1'b1;
          uds_l_d   = 1'b1;
          lds_l_d   = 1'b1;
          data_oe_d = 1'b0;
          to_cnt_d  = '0;
          state_d   = RELEASE;
        end
      end

      // Wait for the responder to negate DTACK before taking new work.
      RELEASE: begin
        if (dtack_l) begin
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops the strobes immediately.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset_H) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      to_cnt_q    <= '0;
      be_q        <= BE_WORD;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      read_data_q <= '0;
      addr_q      <= '0;
      rw_l_q      <= RW_READ;
      as_l_q      <= 1'b1;
      uds_l_q     <= 1'b1;
      lds_l_q     <= 1'b1;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      to_cnt_q    <= to_cnt_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      bus_err_q   <= bus_err_d;
      read_data_q <= read_data_d;
      addr_q      <= addr_d;
      rw_l_q      <= rw_l_d;
      as_l_q      <= as_l_d;
      uds_l_q     <= uds_l_d;
      lds_l_q     <= lds_l_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign ReqReady_H      = req_ready_q;
  assign Done_H          = done_q;
  assign BusError_H      = bus_err_q;
  assign ReadData        = read_data_q;
  assign AddressOut      = addr_q;
  assign RW_L            = rw_l_q;
  assign AS_L            = as_l_q;
  assign UDS_L           = uds_l_q;
  assign LDS_L           = lds_l_q;
  assign DataOut         = data_out_q;
  assign DataOutEnable_H = data_oe_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Self-checking bench for m68k_bus_master. A behavioural responder drives
// DtackIn_L after a programmable number of wait states and can hold it low
// after AS_L rises. Expected timing per transaction comes from cycle
// arithmetic on the bus protocol rules; honours M68K_BUS_MASTER_DTACK_SYNC_EN.
module tb_m68k_bus_master;

  localparam int AW    = 23;
  localparam int DW    = 16;
  localparam int TO    = 8;
  localparam int NEVER = 1000;
`ifdef M68K_BUS_MASTER_DTACK_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic          Clk = 1'b0;
  logic          Reset_H = 1'b1;
  logic          ReqValid_H = 1'b0;
  logic          ReqReady_H;
  logic          ReqWrite_H = 1'b0;
  logic [AW-1:0] ReqAddress = '0;
  logic [1:0]    ReqByteEn = 2'b00;
  logic [DW-1:0] ReqWriteData = '0;
  logic          Done_H, BusError_H;
  logic [DW-1:0] ReadData;
  logic [AW-1:0] AddressOut;
  logic          RW_L, AS_L, UDS_L, LDS_L;
  logic [DW-1:0] DataOut;
  logic          DataOutEnable_H;
  logic [DW-1:0] DataIn = '0;
  logic          DtackIn_L;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_wait = NEVER;
  int resp_hold = 0;
  int as_cnt  = 0;
  int rel_cnt = 0;
  logic [DW-1:0] model_rdata = '0;

  m68k_bus_master #(
    .ADDR_W(AW), .DATA_W(DW), .SETUP_CYCLES(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .Reset_H(Reset_H),
    .ReqValid_H(ReqValid_H), .ReqReady_H(ReqReady_H), .ReqWrite_H(ReqWrite_H),
    .ReqAddress(ReqAddress), .ReqByteEn(ReqByteEn), .ReqWriteData(ReqWriteData),
    .Done_H(Done_H), .BusError_H(BusError_H), .ReadData(ReadData),
    .AddressOut(AddressOut), .RW_L(RW_L), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .DataOut(DataOut), .DataOutEnable_H(DataOutEnable_H),
    .DataIn(DataIn), .DtackIn_L(DtackIn_L)
  );

  always #5 Clk = ~Clk;

  // Responder: acknowledge once AS_L has been low resp_wait cycles, then
  // keep DTACK low resp_hold cycles after the strobe is withdrawn.
  always @(posedge Clk) begin
    cyc    <= cyc + 1;
    as_cnt <= AS_L ? 0 : as_cnt + 1;
    if (!AS_L && !DtackIn_L) rel_cnt <= resp_hold;
    else if (rel_cnt != 0)   rel_cnt <= rel_cnt - 1;
  end

  assign DtackIn_L = !((!AS_L && as_cnt >= resp_wait) || rel_cnt != 0);

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    total++;
    if ({ReqReady_H, Done_H, BusError_H, ReadData, AddressOut, RW_L, AS_L, UDS_L, LDS_L,
         DataOut, DataOutEnable_H} !== {1'b1, 1'b0, 1'b0, 16'h0, 23'h0, 1'b1, 1'b1, 1'b1,
         1'b1, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: rdy=%b done=%b err=%b rd=%h addr=%h rw=%b as=%b uds=%b lds=%b do=%h oe=%b",
               ReqReady_H, Done_H, BusError_H, ReadData, AddressOut, RW_L, AS_L, UDS_L, LDS_L,
               DataOut, DataOutEnable_H);
    end
    Reset_H = 1'b0;
    @(negedge Clk);
    total++;
    if ({ReqReady_H, AS_L, Done_H} !== 3'b110) begin
      bad++;
      $display("FAIL reset_release: rdy/as/done=%b want 110", {ReqReady_H, AS_L, Done_H});
    end
  endtask

  // One complete transaction, started at a negedge; returns at the negedge
  // where ReqReady_H is seen high again.
  task automatic do_txn(input string name, input bit wr, input logic [AW-1:0] addr,
                        input logic [1:0] be, input logic [DW-1:0] wd,
                        input logic [DW-1:0] din, input int w, input int h,
                        input bit hold_valid);
    int a, rel, n_done, as_low, done_rel, ready_rel, exp_done, exp_ready;
    bit ok, err_seen;
    logic exp_oe;
    logic [1:0] bev;
    logic [DW-1:0] rd_seen, exp_rd;

    bev       = (be == 2'b00) ? 2'b11 : be;
    ok        = (w + SYNC + 1 <= TO);
    exp_done  = ok ? 3 + w + SYNC : 2 + TO;
    exp_ready = ok ? exp_done + 1 + h + SYNC : exp_done + 1;
    exp_rd    = (ok && !wr) ? din : model_rdata;

    ReqValid_H = 1'b1; ReqWrite_H = wr; ReqAddress = addr; ReqByteEn = be;
    ReqWriteData = wd; DataIn = din; resp_wait = w; resp_hold = h;

    for (int i = 0; i < 200 && ReqReady_H !== 1'b1; i++) @(negedge Clk);
    total++;
    if (ReqReady_H !== 1'b1) begin
      bad++;
      $display("FAIL %s accept_wait: ReqReady_H=%b want 1", name, ReqReady_H);
    end

    a = cyc + 1;
    n_done = 0; as_low = 0; done_rel = -1; ready_rel = -1; err_seen = 0; rd_seen = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      rel = cyc - a;
      if (rel == 0 && !hold_valid) ReqValid_H = 1'b0;
      if (AS_L === 1'b0) begin
        as_low++;
        total++;
        if ({AddressOut, RW_L, UDS_L, LDS_L} !== {addr, !wr, !bev[1], !bev[0]}) begin
          bad++;
          $display("FAIL %s strobe: addr=%h rw=%b uds=%b lds=%b want addr=%h rw=%b uds=%b lds=%b",
                   name, AddressOut, RW_L, UDS_L, LDS_L, addr, !wr, !bev[1], !bev[0]);
        end
      end
      exp_oe = wr && (rel < exp_done);
      total++;
      if (DataOutEnable_H !== exp_oe || (exp_oe && DataOut !== wd)) begin
        bad++;
        $display("FAIL %s data_out rel=%0d: oe=%b do=%h want oe=%b do=%h",
                 name, rel, DataOutEnable_H, DataOut, exp_oe, wd);
      end
      if (Done_H === 1'b1) begin
        n_done++;
        if (done_rel < 0) begin
          done_rel = rel; err_seen = BusError_H; rd_seen = ReadData;
        end
      end
      if (ReqReady_H === 1'b1) begin
        ready_rel = rel;
        break;
      end
    end

    total++;
    if (n_done != 1 || done_rel != exp_done) begin
      bad++;
      $display("FAIL %s done: pulses=%0d at=%0d want pulses=1 at=%0d", name, n_done, done_rel, exp_done);
    end
    total++;
    if (as_low != exp_done - 2) begin
      bad++;
      $display("FAIL %s as_width: got=%0d want=%0d", name, as_low, exp_done - 2);
    end
    total++;
    if (err_seen != !ok || rd_seen !== exp_rd) begin
      bad++;
      $display("FAIL %s result: err=%b rd=%h want err=%b rd=%h", name, err_seen, rd_seen, !ok, exp_rd);
    end
    total++;
    if (ready_rel != exp_ready || ReadData !== exp_rd) begin
      bad++;
      $display("FAIL %s ready: at=%0d rd=%h want at=%0d rd=%h", name, ready_rel, ReadData, exp_ready, exp_rd);
    end
    model_rdata = exp_rd;
  endtask

  task automatic test_read_zero_wait();
    do_txn("read0", 1'b0, 23'h000400, 2'b11, 16'h0, 16'hBEEF, 0, 0, 1'b0);
  endtask

  task automatic test_write_wait();
    do_txn("write3", 1'b1, 23'h0007F0, 2'b10, 16'h1234, 16'h5555, 3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 1'b0, 23'h123456, 2'b11, 16'h0, 16'hDEAD, NEVER, 0, 1'b0);
    do_txn("tie", 1'b0, 23'h000222, 2'b01, 16'h0, 16'hC0DE, TO - 1 - SYNC, 0, 1'b0);
  endtask

  task automatic test_late_release();
    do_txn("late_rel", 1'b1, 23'h000ABC, 2'b11, 16'h7777, 16'h0, 1, 4, 1'b1);
    do_txn("after_late", 1'b0, 23'h000ABD, 2'b01, 16'h0, 16'h4242, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_strobe();
    int n_done = 0;
    ReqValid_H = 1'b1; ReqWrite_H = 1'b1; ReqAddress = 23'h0055AA; ReqByteEn = 2'b11;
    ReqWriteData = 16'hA5A5; resp_wait = NEVER; resp_hold = 0;
    @(negedge Clk);
    ReqValid_H = 1'b0;
    for (int i = 0; i < 20 && AS_L !== 1'b0; i++) @(negedge Clk);
    @(negedge Clk);
    total++;
    if (AS_L !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_enter: AS_L=%b want 0", AS_L);
    end
    Reset_H = 1'b1;
    @(negedge Clk);
    if (Done_H === 1'b1) n_done++;
    total++;
    if ({AS_L, UDS_L, LDS_L, DataOutEnable_H, Done_H} !== 5'b11100) begin
      bad++;
      $display("FAIL rst_mid_strobes: as/uds/lds/oe/done=%b want 11100",
               {AS_L, UDS_L, LDS_L, DataOutEnable_H, Done_H});
    end
    @(negedge Clk);
    Reset_H = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Done_H === 1'b1) n_done++;
    end
    total++;
    if (ReqReady_H !== 1'b1 || n_done != 0 || ReadData !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid_after: rdy=%b done_pulses=%0d rd=%h want rdy=1 done_pulses=0 rd=0000",
               ReqReady_H, n_done, ReadData);
    end
    model_rdata = '0;
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_a", 1'b0, 23'h000010, 2'b11, 16'h0, 16'h1010, 0, 0, 1'b1);
    do_txn("b2b_b", 1'b0, 23'h000011, 2'b11, 16'h0, 16'h1111, 0, 0, 1'b1);
    do_txn("be00", 1'b0, 23'h000012, 2'b00, 16'h0, 16'h1212, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    bit wr, hv;
    int w, h;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom % 2);
      hv = 1'($urandom % 2);
      w  = ($urandom % 5 == 0) ? NEVER : int'($urandom_range(0, TO - 1 - SYNC));
      h  = int'($urandom_range(0, 3));
      do_txn("rand", wr, AW'($urandom), 2'($urandom), DW'($urandom), DW'($urandom), w, h, hv);
    end
    ReqValid_H = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_late_release();
    test_reset_mid_strobe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m68k_bus_master.md
Name: m68k_bus_master

Overview:
- Single-channel 68000-style asynchronous bus initiator.
- Takes one read or write request at a time from a local client (DMA/SPI engine) and runs a full AS/UDS/LDS cycle.
- Waits for the DTACK returned by the system Dtack generator, then releases the strobes.
- Completion is reported with a one-cycle Done pulse, plus a bus error if no DTACK arrives within a timeout.

Parameters:
- ADDR_W, 23, word address width (A23..A1)
- DATA_W, 16, bus data width
- SETUP_CYCLES, 1, cycles that address/RW/data are held valid before AS_L asserts (min 1)
- TIMEOUT_CYCLES, 255, strobe cycles without DTACK before a bus error (min 2)

Ports:
- Clk  in  1  system clock
- Reset_H  in  1  synchronous active-high reset
- ReqValid_H  in  1  client request strobe
- ReqReady_H  out  1  high only in IDLE; a request is accepted when ReqValid_H and ReqReady_H are both high
- ReqWrite_H  in  1  1=write, 0=read
- ReqAddress  in  ADDR_W  word address
- ReqByteEn  in  2  [1]=upper byte, [0]=lower byte
- ReqWriteData  in  DATA_W  write data
- Done_H  out  1  one-cycle completion pulse
- BusError_H  out  1  valid with Done_H; 1 = timed out
- ReadData  out  DATA_W  data captured on a read; holds until the next successful read
- AddressOut  out  ADDR_W  to address decoder
- RW_L  out  1  1=read, 0=write
- AS_L, UDS_L, LDS_L  out  1 each  bus strobes
- DataOut  out  DATA_W  write data to bus
- DataOutEnable_H  out  1  tri-state enable for DataOut
- DataIn  in  DATA_W  read data from bus
- DtackIn_L  in  1  from Dtack generator

Behaviour:
- Reset values: ReqReady_H=1, Done_H=0, BusError_H=0, ReadData=0, AddressOut=0, RW_L=1, AS_L=UDS_L=LDS_L=1, DataOut=0, DataOutEnable_H=0. Timeout counter=0. State=IDLE.
- Reset mid-cycle: strobes deassert at the reset edge, FSM goes to IDLE, no Done_H is issued.
- All registered outputs change on the rising edge of Clk.
- States:
  - IDLE: ReqReady_H=1. On accept, latch the request, drive AddressOut and RW_L, and go to SETUP. For writes, also drive DataOut with DataOutEnable_H=1. ReqByteEn=00 is promoted to 11.
  - SETUP: hold for SETUP_CYCLES with AS_L=1, then go to STROBE.
  - STROBE: AS_L=0, UDS_L=~ByteEn[1], LDS_L=~ByteEn[0]. The counter increments each cycle.
    - dtack sampled low: capture DataIn into ReadData (reads only), go to RELEASE.
    - counter reaches TIMEOUT_CYCLES without dtack: go to RELEASE with the error flag set.
    - dtack and timeout in the same cycle: dtack wins, no error.
  - RELEASE: AS_L=UDS_L=LDS_L=1, DataOutEnable_H=0, and Done_H pulses in the first cycle of RELEASE. BusError_H=1 with Done_H only on timeout; ReadData is unchanged on error.
    - Remain in RELEASE until dtack is sampled high, then go to IDLE, so the responder's DTACK is negated before a new cycle.
    - No timeout applies in RELEASE.
- Minimum latency, SETUP_CYCLES=1, DTACK immediate, no sync: accept at edge 0, AS_L low from edge 2, Done_H at edge 3, ReqReady_H back at edge 4.
- Back-to-back requests: the next accept occurs no earlier than the cycle after returning to IDLE.
- Request inputs are ignored outside IDLE.

Optional Feature:
- Macro: M68K_BUS_MASTER_DTACK_SYNC_EN.
- Defined: DtackIn_L passes through a 2-flop synchronizer, reset to 1, before FSM use. Used when the responder is asynchronous. DTACK and release detection each gain 2 cycles of latency. Timeout counting is unchanged (still counts STROBE cycles).
- Undefined: DtackIn_L is sampled directly; the responder must be synchronous to Clk.

Decomposition:
- Package m68k_bus_pkg: state enum (IDLE, SETUP, STROBE, RELEASE), RW encodings (RW_READ=1, RW_WRITE=0), byte-enable constants (BE_UPPER, BE_LOWER, BE_WORD).
- Sub-module dtack_sync: 2-flop synchronizer with synchronous active-high reset to 1. Instantiated only under the macro.

Test Plan:
- Read, zero-wait: ReqAddress=23'h000400, ByteEn=11, responder pulls DtackIn_L low combinationally when AS_L=0, DataIn=16'hBEEF -> AS_L low for 1 cycle, UDS_L=LDS_L=0, RW_L=1, Done_H=1, BusError_H=0, ReadData=16'hBEEF.
- Write with 3 wait states: ReqWrite_H=1, ReqWriteData=16'h1234, ByteEn=10, DTACK 3 cycles after AS_L low -> DataOutEnable_H=1 from accept through STROBE, UDS_L=0, LDS_L=1, RW_L=0, AS_L low for 4 cycles, single Done_H, no error.
- Timeout: TIMEOUT_CYCLES=8, DtackIn_L held high -> AS_L low for exactly 8 cycles, Done_H=1 with BusError_H=1, ReadData keeps its prior value, ReqReady_H returns next cycle.
- Late DTACK release: responder holds DtackIn_L low 4 cycles after AS_L rises -> FSM stays in RELEASE, ReqReady_H=0 until dtack is high, and a pending ReqValid_H is not accepted early.
- Reset mid-STROBE: assert Reset_H while AS_L=0 -> next edge AS_L=UDS_L=LDS_L=1, DataOutEnable_H=0, Done_H never pulses, ReqReady_H=1 after release of reset.
- Back-to-back plus edge case: two reads to 23'h10 and 23'h11 with ReqValid_H held high, then a request with ByteEn=00 -> two Done_H pulses in order; the ByteEn=00 request drives UDS_L=LDS_L=0. Under M68K_BUS_MASTER_DTACK_SYNC_EN, each Done_H is 2 cycles later than without the macro.
